// File: rtl/decoder_link_framer_pkg.sv
// Shared link constants and state encoding for the decoder host-side framer.
package decoder_link_framer_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StTxStart,
        StTxHdr,
        StTxPay,
        StRx,
        StResult
    } link_state_t;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/link_byte_unpacker.sv
// Collects link beats into a flat little-endian byte record; bytes beyond the record are dropped.
module link_byte_unpacker #(
    parameter int unsigned LINK_BYTES  = 1,
    parameter int unsigned TOTAL_BYTES = 45
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     beat_valid,
    input  logic [LINK_BYTES*8-1:0]  beat_data,
    output logic [TOTAL_BYTES*8-1:0] record,
    output logic                     last_beat
);

    localparam int unsigned CW = $clog2(TOTAL_BYTES + LINK_BYTES);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [TOTAL_BYTES*8-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (beat_valid) begin
            cnt_d = cnt_q + CW'(LINK_BYTES);
            for (int unsigned i = 0; i < LINK_BYTES; i++) begin
                if (32'(cnt_q) + i < TOTAL_BYTES) begin
                    acc_d[(32'(cnt_q) + i) * 8 +: 8] = beat_data[i * 8 +: 8];
                end
            end
        end
    end

    // The beat that carries the final record byte completes the record.
    assign last_beat = beat_valid && !clear && (32'(cnt_q) + LINK_BYTES >= TOTAL_BYTES);
    assign record    = acc_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/decoder_link_framer.sv
// Frames one measurement test case towards the decoder and parses its response into a held result.
module decoder_link_framer
    import decoder_link_framer_pkg::*;
#(
    parameter int unsigned LINK_BYTES     = 1,
    parameter int unsigned ROUND_BITS     = 18,
    parameter int unsigned ROUNDS         = 6,
    parameter int unsigned CORR_BITS      = 49,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned RB            = ceil_div(ROUND_BITS, 8),
    localparam int unsigned MEAS_BYTES    = RB * ROUNDS,
    localparam int unsigned CB            = ceil_div(CORR_BITS, 8),
    localparam int unsigned CORR_BYTES    = CB * ROUNDS,
    localparam int unsigned RESP_BYTES    = 3 + CORR_BYTES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [MEAS_BYTES*8-1:0] meas_data,
    input  logic                    meas_valid,
    output logic                    meas_ready,
    output logic [LINK_BYTES*8-1:0] tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [LINK_BYTES*8-1:0] rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [7:0]              result_iterations,
    output logic [15:0]             result_cycles,
    output logic [CORR_BYTES*8-1:0] result_corrections,
    output logic                    timeout_err
);

    localparam int unsigned PAY_BEATS = ceil_div(MEAS_BYTES, LINK_BYTES);
    localparam int unsigned PW        = (PAY_BEATS > 1) ? $clog2(PAY_BEATS) : 1;
    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);

    link_state_t             state_q, state_d;
    logic                    start_sent_q, start_sent_d;
    logic [MEAS_BYTES*8-1:0] shadow_q, shadow_d;
    logic [PW-1:0]           pay_beat_q, pay_beat_d;
    logic [TW-1:0]           timeout_q, timeout_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    idle_ready;

    logic [PAY_BEATS*LINK_BYTES*8-1:0] pay_flat;
    logic [RESP_BYTES*8-1:0]           resp_record;
    logic                              rx_beat;
    logic                              rx_last;

    // Payload beats past the end of the shadow carry zero bytes.
    always_comb begin
        pay_flat                   = '0;
        pay_flat[MEAS_BYTES*8-1:0] = shadow_q;
    end

    assign rx_beat = rx_valid && (state_q == StRx);

    link_byte_unpacker #(
        .LINK_BYTES  (LINK_BYTES),
        .TOTAL_BYTES (RESP_BYTES)
    ) u_unpacker (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (state_q != StRx),
        .beat_valid (rx_beat),
        .beat_data  (rx_data),
        .record     (resp_record),
        .last_beat  (rx_last)
    );

    always_comb begin
        state_d       = state_q;
        start_sent_d  = start_sent_q;
        shadow_d      = shadow_q;
        pay_beat_d    = pay_beat_q;
        timeout_d     = timeout_q;
        timeout_err_d = timeout_err_q;
        idle_ready    = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = '0;
        rx_ready      = 1'b0;
        result_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                idle_ready = 1'b1;
                if (meas_valid) begin
                    shadow_d = meas_data;
                    state_d  = start_sent_q ? StTxHdr : StTxStart;
                end
            end
            StTxStart: begin
                tx_valid     = 1'b1;
                tx_data[7:0] = START_DECODING_MSG;
                if (tx_ready) begin
                    start_sent_d = 1'b1;
                    state_d      = StTxHdr;
                end
            end
            StTxHdr: begin
                tx_valid     = 1'b1;
                tx_data[7:0] = MEASUREMENT_DATA_HEADER;
                if (tx_ready) begin
                    pay_beat_d = '0;
                    state_d    = StTxPay;
                end
            end
            StTxPay: begin
                tx_valid = 1'b1;
                tx_data  = pay_flat[32'(pay_beat_q) * LINK_BYTES * 8 +: LINK_BYTES * 8];
                if (tx_ready) begin
                    if (pay_beat_q == PW'(PAY_BEATS - 1)) begin
                        timeout_d = '0;
                        state_d   = StRx;
                    end else begin
                        pay_beat_d = pay_beat_q + 1'b1;
                    end
                end
            end
            StRx: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    timeout_d = '0;
                    if (rx_last) begin
                        state_d = StResult;
                    end
                end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Decoder went silent: drop the partial response and flag it permanently.
                    timeout_err_d = 1'b1;
                    timeout_d     = '0;
                    state_d       = StIdle;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            StResult: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Keep meas_ready low while reset is held so every output reads zero during reset.
    assign meas_ready         = idle_ready && reset_n;
    assign timeout_err        = timeout_err_q;
    assign result_iterations  = resp_record[7:0];
    assign result_cycles      = {resp_record[15:8], resp_record[23:16]};
    assign result_corrections = resp_record[RESP_BYTES*8-1:24];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            start_sent_q  <= 1'b0;
            shadow_q      <= '0;
            pay_beat_q    <= '0;
            timeout_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_sent_q  <= start_sent_d;
            shadow_q      <= shadow_d;
            pay_beat_q    <= pay_beat_d;
            timeout_q     <= timeout_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule
